// File: rtl/inv_pipe_if.sv
// inv_pipe_if -- handshake and mask bus for the inv_pipe block.
//   a / in_valid / in_ready    : upstream word handshake
//   mask_in / mask_load        : mask register load port
//   y / out_valid / out_ready  : downstream word handshake
//   mask / xfer_count          : status outputs
// The slave modport is the pipeline. The master modport is its environment.
interface inv_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] mask_in;
  logic             mask_load;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] mask;
  logic [15:0]      xfer_count;

  modport master (
    output a, in_valid, mask_in, mask_load, out_ready,
    input  in_ready, y, out_valid, mask, xfer_count
  );

  modport slave (
    input  a, in_valid, mask_in, mask_load, out_ready,
    output in_ready, y, out_valid, mask, xfer_count
  );
endinterface

// File: rtl/inv_pipe.sv
// inv_pipe -- elastic pipeline that XORs each accepted word with a
// programmable inversion mask.
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : inv_pipe_if slave. It carries the input handshake (a/in_valid/in_ready),
//          the mask load port (mask_in/mask_load), the output handshake
//          (y/out_valid/out_ready), and status (mask, xfer_count).
// Each accepted word is masked on entry to stage 1 and then moves forward
// through STAGES valid/data registers. Every stage can fill while the
// stages downstream of it are stalled, so the pipe never inserts bubbles.
module inv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  inv_pipe_if.slave   bus
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [15:0]       xfer_count_q, xfer_count_d;

  // ready[i]: stage i may load this edge. ready[STAGES] is the downstream sink.
  logic [STAGES:0]   ready;
  logic              out_fire;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
    ready          = '0;
    ready[STAGES]  = bus.out_ready;
    // A stage can load when it is empty or when its own word moves on this edge.
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready[i] = !valid_q[i] || ready[i+1];
    end

    out_fire     = valid_q[STAGES-1] && bus.out_ready;

    valid_d      = valid_q;
    data_d       = data_q;
    mask_d       = bus.mask_load ? bus.mask_in : mask_q;
    xfer_count_d = out_fire ? xfer_count_q + 16'd1 : xfer_count_q;

    // Stage 1 uses the mask held before this edge, even when a new mask loads on the same edge.
    if (ready[0]) begin
      valid_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        data_d[0] = bus.a ^ mask_q;
      end
    end

    for (int i = 1; i < STAGES; i++) begin
      if (ready[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      mask_q       <= '1;
      xfer_count_q <= '0;
      // NOTE: the stage data array is reset too, so every stage reads zero during reset.
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that all registers update together.
      valid_q      <= valid_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // in_ready is held low during reset, so it can rise only after reset is released.
  assign bus.in_ready   = ready[0] && !rst;
  assign bus.y          = data_q[STAGES-1];
  assign bus.out_valid  = valid_q[STAGES-1];
  assign bus.mask       = mask_q;
  assign bus.xfer_count = xfer_count_q;

endmodule
